// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle add/sub/logic/compare, one-bit-per-cycle shifts.
// Valid/ready on both sides lets the pipeline stall EX while a shift is in flight.
module alu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    // Encoding is {funct7[5], funct3}, the same codes the ALU control decoder emits.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [XLEN-1:0] shift_q;
    logic [SHW-1:0]  cnt_q;
    logic [3:0]      funct_q;

    logic [XLEN-1:0] xor_w;
    logic [XLEN-1:0] or_w;
    logic [XLEN-1:0] and_w;
    logic [XLEN-1:0] sum_w;
    logic [XLEN:0]   diff_w;
    logic            lt_unsigned_w;
    logic            lt_signed_w;
    logic [XLEN-1:0] alu_res_w;
    logic            is_shift_w;
    logic [SHW-1:0]  shamt_w;
    logic [XLEN-1:0] shift_d;
    logic [SHW-1:0]  cnt_d;
    logic            accept_w;

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_bitwise
            assign xor_w[gi] = op_a[gi] ^ op_b[gi];
            assign or_w[gi]  = op_a[gi] | op_b[gi];
            assign and_w[gi] = op_a[gi] & op_b[gi];
        end
    endgenerate

    // One widened subtractor serves SUB, SLTU (borrow out) and SLT.
    assign sum_w         = op_a + op_b;
    assign diff_w        = {1'b0, op_a} - {1'b0, op_b};
    assign lt_unsigned_w = diff_w[XLEN];
    // Differing signs: A is less exactly when A is negative; otherwise the difference cannot overflow.
    assign lt_signed_w   = (op_a[XLEN-1] != op_b[XLEN-1]) ? op_a[XLEN-1] : diff_w[XLEN-1];

    always_comb begin
        alu_res_w = sum_w;
        case (alu_funct)
            ALU_ADD:  alu_res_w = sum_w;
            ALU_SUB:  alu_res_w = diff_w[XLEN-1:0];
            ALU_SLT:  alu_res_w = {{(XLEN-1){1'b0}}, lt_signed_w};
            ALU_SLTU: alu_res_w = {{(XLEN-1){1'b0}}, lt_unsigned_w};
            ALU_XOR:  alu_res_w = xor_w;
            ALU_OR:   alu_res_w = or_w;
            ALU_AND:  alu_res_w = and_w;
            default:  alu_res_w = sum_w;
        endcase
    end

    assign is_shift_w = (alu_funct == ALU_SLL) || (alu_funct == ALU_SRL) || (alu_funct == ALU_SRA);
    assign shamt_w    = op_b[SHW-1:0];
    assign accept_w   = in_valid && in_ready_q && !flush;

    // Single-position step of the latched shift; SRA replicates the sign bit it was loaded with.
    always_comb begin
        shift_d = {1'b0, shift_q[XLEN-1:1]};
        case (funct_q)
            ALU_SLL: shift_d = {shift_q[XLEN-2:0], 1'b0};
            ALU_SRA: shift_d = {shift_q[XLEN-1], shift_q[XLEN-1:1]};
            default: shift_d = {1'b0, shift_q[XLEN-1:1]};
        endcase
    end

    assign cnt_d = cnt_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            shift_q     <= '0;
            cnt_q       <= '0;
            funct_q     <= ALU_ADD;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_w) begin
                        in_ready_q <= 1'b0;
                        funct_q    <= alu_funct;
                        if (is_shift_w) begin
                            shift_q <= op_a;
                            cnt_q   <= shamt_w;
                            if (shamt_w == '0) begin
                                result_q    <= op_a;
                                zero_q      <= (op_a == '0);
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                state_q <= S_SHIFT;
                            end
                        end else begin
                            result_q    <= alu_res_w;
                            zero_q      <= (alu_res_w == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_d;
                    if (cnt_d == '0) begin
                        result_q    <= shift_d;
                        zero_q      <= (shift_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed plus random transactions against an arithmetic reference model of the iterative ALU.
module tb_alu_iterative;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SLL  = 4'b0001;
    localparam logic [3:0] F_SLT  = 4'b0010;
    localparam logic [3:0] F_SLTU = 4'b0011;
    localparam logic [3:0] F_XOR  = 4'b0100;
    localparam logic [3:0] F_SRL  = 4'b0101;
    localparam logic [3:0] F_OR   = 4'b0110;
    localparam logic [3:0] F_AND  = 4'b0111;
    localparam logic [3:0] F_SUB  = 4'b1000;
    localparam logic [3:0] F_SRA  = 4'b1101;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_iterative #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_funct (alu_funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = int'(b[4:0]);
        sa = a;
        case (f)
            F_SUB:   return a - b;
            F_SLL:   return a << sh;
            F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            F_XOR:   return a ^ b;
            F_SRL:   return a >> sh;
            F_SRA:   return 32'(sa >>> sh);
            F_OR:    return a | b;
            F_AND:   return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] f, input logic [31:0] b);
        if (f == F_SLL || f == F_SRL || f == F_SRA) return 1 + int'(b[4:0]);
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; out_ready is held low for 'stall' cycles once the result appears.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        exp_r   = ref_result(f, a, b);
        exp_lat = ref_latency(f, b);
        check({tag, ":in_ready_before"}, {31'd0, in_ready}, 32'd1);
        alu_funct = f;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        step();
        in_valid  = 1'b0;
        // Scramble operands after accept; the block must ignore them.
        alu_funct = 4'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat = 1;
        check({tag, ":in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":result"}, result, exp_r);
        check({tag, ":zero"}, {31'd0, zero}, {31'd0, (exp_r == 32'd0)});
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, ":stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ":stall_result"}, result, exp_r);
        end
        out_ready = 1'b1;
        step();
        check({tag, ":valid_after"}, {31'd0, out_valid}, 32'd0);
        check({tag, ":in_ready_after"}, {31'd0, in_ready}, 32'd1);
        $display("txn %s funct=%h a=%h b=%h result=%h latency=%0d", tag, f, a, b, result, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_funct = F_ADD;
        op_a      = 32'd0;
        op_b      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("reset:in_ready", {31'd0, in_ready}, 32'd1);
        check("reset:out_valid", {31'd0, out_valid}, 32'd0);
        check("reset:result", result, 32'd0);
        check("reset:zero", {31'd0, zero}, 32'd1);
        rst = 1'b0;
        step();

        run_op("add_wrap", F_ADD, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sub", F_SUB, 32'd5, 32'd7, 0);
        run_op("slt", F_SLT, 32'h8000_0000, 32'd1, 0);
        run_op("sltu", F_SLTU, 32'h8000_0000, 32'd1, 0);
        run_op("sra4", F_SRA, 32'h8000_0010, 32'd4, 0);
        run_op("sll0", F_SLL, 32'h1234_5678, 32'd0, 0);
        run_op("sll31", F_SLL, 32'd1, 32'd31, 0);
        run_op("srl8_stall", F_SRL, 32'hF000_0000, 32'd8, 3);
        run_op("unknown", 4'b1111, 32'd10, 32'd20, 0);

        // Flush during the second SHIFT cycle of a shamt=10 op.
        alu_funct = F_SRL;
        op_a      = 32'hDEAD_BEEF;
        op_b      = 32'd10;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush:out_valid", {31'd0, out_valid}, 32'd0);
        check("flush:in_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) step();
        check("flush:no_late_result", {31'd0, out_valid}, 32'd0);
        $display("txn flush_shift out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Flush wins over a simultaneous offer in IDLE.
        alu_funct = F_ADD;
        op_a      = 32'd1;
        op_b      = 32'd2;
        in_valid  = 1'b1;
        flush     = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle:in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_idle:out_valid", {31'd0, out_valid}, 32'd0);
        $display("txn flush_idle out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Reset while a result waits in DONE.
        alu_funct = F_OR;
        op_a      = 32'h0000_00F0;
        op_b      = 32'h0000_000F;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check("rst_done:out_valid_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("rst_done:out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done:in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_done:result", result, 32'd0);
        check("rst_done:zero", {31'd0, zero}, 32'd1);
        $display("txn rst_in_done out_valid=%0d in_ready=%0d", out_valid, in_ready);

        run_op("add_after", F_ADD, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  rf;
            logic [31:0] ra;
            logic [31:0] rb;
            rf = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra = 32'd0;
            run_op($sformatf("rand%0d", i), rf, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
